// File: rtl/ailn_moment_unit.sv
// ailn_moment_unit: one-pass first/second moment engine for AILayerNorm.
// It accumulates N signed samples and returns the rounded E[x] and E[x^2]
// behind a valid/ready handshake.
module ailn_moment_unit #(
    parameter int unsigned N      = 8,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ROUND  = 1
) (
    input  logic                       i_clk,
    input  logic                       i_rstn,
    input  logic                       i_clr,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic signed [DATA_W-1:0]   i_x,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic signed [DATA_W-1:0]   o_ex,
    output logic [2*DATA_W-1:0]        o_ex2
);

    localparam int unsigned S   = $clog2(N);
    localparam int unsigned SW  = DATA_W + S;          // sum accumulator width
    localparam int unsigned PW  = 2*DATA_W - 1;        // square / mean-square width
    localparam int unsigned QW  = PW + S;              // square accumulator width
    localparam int unsigned CW  = S + 1;               // sample counter width
    localparam int unsigned RND = (ROUND != 0) ? (32'd1 << (S - 1)) : 32'd0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_CALC = 2'd2;
    localparam logic [1:0] ST_OUT  = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic                     r_ready;
    logic                     r_valid;
    logic signed [SW-1:0]     r_sum;
    logic [QW-1:0]            r_sq;
    logic [CW-1:0]            r_cnt;
    logic signed [DATA_W-1:0] r_ex;
    logic [PW-1:0]            r_ex2;

    logic                     w_accept;
    logic                     w_last;
    logic [DATA_W-1:0]        w_mag;
    logic [2*DATA_W-1:0]      w_sq;
    logic signed [SW:0]       w_sum_g;
    logic [QW:0]              w_sq_g;
    logic signed [DATA_W-1:0] w_mean;
    logic [PW-1:0]            w_msq;

    assign w_accept = i_valid && r_ready;
    assign w_last   = (r_cnt == CW'(N - 1));

    // Magnitude is unsigned so the most negative input squares without overflow.
    assign w_mag = i_x[DATA_W-1] ? DATA_W'(-i_x) : DATA_W'(i_x);
    assign w_sq  = (2*DATA_W)'(w_mag) * (2*DATA_W)'(w_mag);

    // Rounding bias is added with one guard bit before the divide-by-N shift.
    assign w_sum_g = (SW+1)'(r_sum) + $signed((SW+1)'(RND));
    assign w_sq_g  = (QW+1)'(r_sq) + (QW+1)'(RND);
    assign w_mean  = DATA_W'(w_sum_g >>> S);
    assign w_msq   = PW'(w_sq_g >> S);

    assign o_ready = r_ready;
    assign o_valid = r_valid;
    assign o_ex    = r_ex;
    assign o_ex2   = {1'b0, r_ex2};

    // State register; o_ready is registered alongside from the next state.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_ACC);
        end
    end

    // Next-state logic; clear overrides everything and returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        if (i_clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (w_accept) w_state_nxt = ST_ACC;
                ST_ACC:  if (w_accept && w_last) w_state_nxt = ST_CALC;
                ST_CALC: w_state_nxt = ST_OUT;
                ST_OUT:  if (i_ready) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Accumulators and result registers; results are zeroed whenever not valid.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_sum   <= '0;
            r_sq    <= '0;
            r_cnt   <= '0;
            r_ex    <= '0;
            r_ex2   <= '0;
            r_valid <= 1'b0;
        end else if (i_clr) begin
            r_sum   <= '0;
            r_sq    <= '0;
            r_cnt   <= '0;
            r_ex    <= '0;
            r_ex2   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_sum <= SW'(i_x);
                        r_sq  <= QW'(w_sq);
                        r_cnt <= CW'(1);
                    end
                end
                ST_ACC: begin
                    if (w_accept) begin
                        r_sum <= r_sum + SW'(i_x);
                        r_sq  <= r_sq + QW'(w_sq);
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_CALC: begin
                    r_ex    <= w_mean;
                    r_ex2   <= w_msq;
                    r_valid <= 1'b1;
                    r_sum   <= '0;
                    r_sq    <= '0;
                    r_cnt   <= '0;
                end
                ST_OUT: begin
                    if (i_ready) begin
                        r_ex    <= '0;
                        r_ex2   <= '0;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ailn_moment_unit.sv
// Scoreboard bench for ailn_moment_unit: two N=8/DATA_W=8 instances (round,
// truncate) share stimulus; an N=16/DATA_W=12 instance runs a streaming pass.
module tb_ailn_moment_unit;

    typedef struct {
        longint ex;
        longint ex2;
        longint vcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn, clr, valid, ready, valid_c;
    logic signed [7:0]  xin;
    logic signed [11:0] xc;

    logic rdy_a, vld_a, rdy_b, vld_b, rdy_c, vld_c;
    logic signed [7:0]  ex_a, ex_b;
    logic [15:0]        ex2_a, ex2_b;
    logic signed [11:0] ex_c;
    logic [23:0]        ex2_c;

    int     n_chk  = 0;
    int     n_pass = 0;
    longint cyc    = 0;

    exp_t   qa[$], qb[$], qc[$];
    exp_t   ea, eb, ec;
    longint rises_a[$], rises_c[$];
    logic   prev_a = 1'b0, prev_c = 1'b0;

    longint m_sum_a = 0, m_sq_a = 0, m_sum_c = 0, m_sq_c = 0;
    int     m_cnt_a = 0, m_cnt_c = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ailn_moment_unit #(.N(8), .DATA_W(8), .ROUND(1)) u_dut_a (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_valid(valid), .o_ready(rdy_a),
        .i_x(xin), .o_valid(vld_a), .i_ready(ready), .o_ex(ex_a), .o_ex2(ex2_a));

    ailn_moment_unit #(.N(8), .DATA_W(8), .ROUND(0)) u_dut_b (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_valid(valid), .o_ready(rdy_b),
        .i_x(xin), .o_valid(vld_b), .i_ready(ready), .o_ex(ex_b), .o_ex2(ex2_b));

    ailn_moment_unit #(.N(16), .DATA_W(12), .ROUND(1)) u_dut_c (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .i_valid(valid_c), .o_ready(rdy_c),
        .i_x(xc), .o_valid(vld_c), .i_ready(ready), .o_ex(ex_c), .o_ex2(ex2_c));

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic longint mean_f(input longint sum, input int s, input int r);
        longint b;
        b = (r != 0) ? (longint'(1) <<< (s - 1)) : 0;
        return (sum + b) >>> s;
    endfunction

    function automatic longint msq_f(input longint sq, input int s, input int r);
        longint b;
        b = (r != 0) ? (longint'(1) << (s - 1)) : 0;
        return (sq + b) >> s;
    endfunction

    // Scoreboard for the rounding N=8 instance, including result latency.
    always @(negedge clk) begin
        if (vld_a && !prev_a) begin
            rises_a.push_back(cyc);
            check_val("sb_nonempty_rise_a", longint'(qa.size() > 0), 1);
            if (qa.size() > 0) check_val("valid_latency_a", cyc, qa[0].vcyc);
        end
        prev_a <= vld_a;
        if (vld_a && ready && !clr) begin
            check_val("sb_nonempty_a", longint'(qa.size() > 0), 1);
            if (qa.size() > 0) begin
                ea = qa.pop_front();
                check_val("ex_a", longint'(ex_a), ea.ex);
                check_val("ex2_a", longint'(ex2_a), ea.ex2);
            end
        end
    end

    // Scoreboard for the truncating N=8 instance.
    always @(negedge clk) begin
        if (vld_b && ready && !clr) begin
            check_val("sb_nonempty_b", longint'(qb.size() > 0), 1);
            if (qb.size() > 0) begin
                eb = qb.pop_front();
                check_val("ex_b", longint'(ex_b), eb.ex);
                check_val("ex2_b", longint'(ex2_b), eb.ex2);
            end
        end
    end

    // Scoreboard for the N=16 / DATA_W=12 instance.
    always @(negedge clk) begin
        if (vld_c && !prev_c) begin
            rises_c.push_back(cyc);
            check_val("sb_nonempty_rise_c", longint'(qc.size() > 0), 1);
            if (qc.size() > 0) check_val("valid_latency_c", cyc, qc[0].vcyc);
        end
        prev_c <= vld_c;
        if (vld_c && ready && !clr) begin
            check_val("sb_nonempty_c", longint'(qc.size() > 0), 1);
            if (qc.size() > 0) begin
                ec = qc.pop_front();
                check_val("ex_c", longint'(ex_c), ec.ex);
                check_val("ex2_c", longint'(ex2_c), ec.ex2);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_a(input int x);
        int w = 0;
        exp_t e;
        valid = 1'b1;
        xin   = 8'(x);
        @(negedge clk);
        while (!rdy_a && w < 64) begin @(negedge clk); w++; end
        if (!rdy_a) begin
            check_val("accept_timeout_a", 0, 1);
        end else begin
            m_sum_a += x;
            m_sq_a  += longint'(x) * longint'(x);
            m_cnt_a++;
            if (m_cnt_a == 8) begin
                e.vcyc = cyc + 2;
                e.ex = mean_f(m_sum_a, 3, 1); e.ex2 = msq_f(m_sq_a, 3, 1); qa.push_back(e);
                e.ex = mean_f(m_sum_a, 3, 0); e.ex2 = msq_f(m_sq_a, 3, 0); qb.push_back(e);
                m_sum_a = 0; m_sq_a = 0; m_cnt_a = 0;
            end
        end
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic send_c(input int x);
        int w = 0;
        exp_t e;
        valid_c = 1'b1;
        xc      = 12'(x);
        @(negedge clk);
        while (!rdy_c && w < 64) begin @(negedge clk); w++; end
        if (!rdy_c) begin
            check_val("accept_timeout_c", 0, 1);
        end else begin
            m_sum_c += x;
            m_sq_c  += longint'(x) * longint'(x);
            m_cnt_c++;
            if (m_cnt_c == 16) begin
                e.vcyc = cyc + 2;
                e.ex = mean_f(m_sum_c, 4, 1); e.ex2 = msq_f(m_sq_c, 4, 1); qc.push_back(e);
                m_sum_c = 0; m_sq_c = 0; m_cnt_c = 0;
            end
        end
        @(posedge clk); #1;
        valid_c = 1'b0;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while ((qa.size() + qb.size() + qc.size()) > 0 && w < 64) begin @(posedge clk); w++; end
        #1;
        check_val(tag, longint'(qa.size() + qb.size() + qc.size()), 0);
    endtask

    task automatic wait_valid_a();
        int w = 0;
        @(negedge clk);
        while (!vld_a && w < 64) begin @(negedge clk); w++; end
        check_val("wait_valid_a", longint'(vld_a), 1);
    endtask

    task automatic check_idle_a(input string tag);
        check_val({tag, "_valid"}, longint'(vld_a), 0);
        check_val({tag, "_ex"}, longint'(ex_a), 0);
        check_val({tag, "_ex2"}, longint'(ex2_a), 0);
        check_val({tag, "_ready"}, longint'(rdy_a), 1);
    endtask

    task automatic discard_ab();
        if (qa.size() > 0) void'(qa.pop_front());
        if (qb.size() > 0) void'(qb.pop_front());
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt_v;
        rstn = 1'b0; clr = 1'b0; valid = 1'b0; ready = 1'b0; xin = '0;
        valid_c = 1'b0; xc = '0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_a("reset_a");
        check_val("reset_ready_c", longint'(rdy_c), 1);
        check_val("reset_valid_c", longint'(vld_c), 0);
        rstn = 1'b1;
        idle(1);

        // Ascending 1..8: mean 5, mean-square 26 (rounded).
        ready = 1'b1;
        for (int i = 1; i <= 8; i++) send_a(i);
        drain("drain_ramp");

        // Most negative input throughout.
        for (int i = 0; i < 8; i++) send_a(-128);
        drain("drain_minneg");

        // Rounding vs truncation of a small negative sum.
        send_a(-4);
        for (int i = 0; i < 7; i++) send_a(0);
        drain("drain_round");

        // Backpressure: result held five cycles while a sample is offered.
        ready = 1'b0;
        for (int i = 0; i < 8; i++) send_a(int'($urandom_range(0, 255)) - 128);
        wait_valid_a();
        valid = 1'b1; xin = 8'sd55;
        for (int k = 0; k < 5; k++) begin
            check_val("bp_valid", longint'(vld_a), 1);
            check_val("bp_ready", longint'(rdy_a), 0);
            if (qa.size() > 0) begin
                check_val("bp_ex", longint'(ex_a), qa[0].ex);
                check_val("bp_ex2", longint'(ex2_a), qa[0].ex2);
            end
            @(negedge clk);
        end
        @(posedge clk); #1;
        valid = 1'b0; ready = 1'b1;
        @(posedge clk); #1;
        check_idle_a("bp_after");
        drain("drain_bp");

        // Clear after five gapped samples; the partial vector is discarded.
        for (int i = 0; i < 5; i++) begin
            idle(int'($urandom_range(0, 3)));
            send_a(int'($urandom_range(0, 255)) - 128);
        end
        clr = 1'b1; valid = 1'b1; xin = 8'sd99;
        idle(1);
        clr = 1'b0; valid = 1'b0;
        m_sum_a = 0; m_sq_a = 0; m_cnt_a = 0;
        cnt_v = 0;
        for (int k = 0; k < 12; k++) begin @(negedge clk); if (vld_a) cnt_v++; end
        check_val("clr_no_valid", longint'(cnt_v), 0);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            idle(int'($urandom_range(0, 3)));
            send_a(int'($urandom_range(0, 255)) - 128);
        end
        drain("drain_after_clr");

        // Clear during OUT drops the pending result.
        ready = 1'b0;
        for (int i = 0; i < 8; i++) send_a(int'($urandom_range(0, 255)) - 128);
        wait_valid_a();
        @(posedge clk); #1;
        discard_ab();
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check_idle_a("clr_out");
        ready = 1'b1;

        // Streaming four vectors: one result every ten cycles.
        rises_a.delete();
        for (int v = 0; v < 4; v++)
            for (int i = 0; i < 8; i++) send_a(int'($urandom_range(0, 255)) - 128);
        drain("drain_stream");
        check_val("stream_results", longint'(rises_a.size()), 4);
        for (int i = 1; i < rises_a.size(); i++)
            check_val("stream_spacing", rises_a[i] - rises_a[i-1], 10);

        // Asynchronous reset while a result is held, then mid-vector.
        ready = 1'b0;
        for (int i = 0; i < 8; i++) send_a(int'($urandom_range(0, 255)) - 128);
        wait_valid_a();
        #2 rstn = 1'b0;
        #1 check_idle_a("rst_out");
        @(posedge clk); #1;
        discard_ab();
        rstn = 1'b1;
        ready = 1'b1;
        for (int i = 0; i < 3; i++) send_a(int'($urandom_range(0, 255)) - 128);
        #2 rstn = 1'b0;
        #1 check_idle_a("rst_mid");
        m_sum_a = 0; m_sq_a = 0; m_cnt_a = 0;
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) send_a(int'($urandom_range(0, 255)) - 128);
        drain("drain_after_rst");

        // Wide configuration: extremes, rounding case and random vectors.
        rises_c.delete();
        for (int i = 0; i < 16; i++) send_c(-2048);
        send_c(-4);
        for (int i = 0; i < 15; i++) send_c(0);
        for (int v = 0; v < 2; v++)
            for (int i = 0; i < 16; i++) send_c(int'($urandom_range(0, 4095)) - 2048);
        drain("drain_c");
        check_val("stream_results_c", longint'(rises_c.size()), 4);
        for (int i = 1; i < rises_c.size(); i++)
            check_val("stream_spacing_c", rises_c[i] - rises_c[i-1], 18);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
